// File: rtl/partition_error_sweeper_if.sv
// Handshake and result bus between a sweep controller and the partition error sweeper.
// The master drives run control and the partition responses; the slave (the sweeper) drives pi and metrics.
`timescale 1ns/1ps
interface partition_error_sweeper_if #(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 4
);
    logic                start;
    logic                mode;
    logic [NUM_IN-1:0]   seed;
    logic [NUM_IN:0]     num_vectors;
    logic [NUM_IN-1:0]   pi;
    logic [NUM_OUT-1:0]  po_exact;
    logic [NUM_OUT-1:0]  po_approx;
    logic                busy;
    logic                done;
    logic [NUM_IN:0]     err_count;
    logic [NUM_IN+5:0]   hd_sum;
    logic [NUM_OUT-1:0]  max_abs_err;
    logic [NUM_IN-1:0]   first_err_vec;
    logic                first_err_valid;

    modport master (
        output start, mode, seed, num_vectors, po_exact, po_approx,
        input  pi, busy, done, err_count, hd_sum, max_abs_err, first_err_vec, first_err_valid
    );

    modport slave (
        input  start, mode, seed, num_vectors, po_exact, po_approx,
        output pi, busy, done, err_count, hd_sum, max_abs_err, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/partition_error_sweeper.sv
// Sweeps pi over an exact and an approximate partition and accumulates error metrics on-chip.
// Optional feature macro: SWEEP_LFSR_EN adds a seeded Galois-LFSR sampling mode.
`timescale 1ns/1ps
module partition_error_sweeper #(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 4,
    parameter int SETTLE  = 1
) (
    input  logic clk,
    input  logic rst_n,
    partition_error_sweeper_if.slave bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       settle_q;
    logic [NUM_IN-1:0]   pi_q;
    logic [NUM_IN-1:0]   start_vec;
    logic [NUM_IN-1:0]   next_vec;
    logic [NUM_IN:0]     err_count_q;
    logic [NUM_IN+5:0]   hd_sum_q;
    logic [NUM_OUT-1:0]  max_abs_err_q;
    logic [NUM_IN-1:0]   first_err_vec_q;
    logic                first_err_valid_q;
    logic [NUM_OUT-1:0]  diff_bits;
    logic [NUM_OUT-1:0]  abs_diff;
    logic                accept, sample, last_vec, zero_run, mismatch;

`ifdef SWEEP_LFSR_EN
    // Galois right-shift toggle masks of maximal-length polynomials, indexed by width.
    function automatic logic [15:0] tap_mask(input int width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0006;
        endcase
    endfunction

    localparam logic [NUM_IN-1:0] TAPS        = NUM_IN'(tap_mask(NUM_IN));
    localparam logic [NUM_IN:0]   MAX_VECTORS = {1'b0, {NUM_IN{1'b1}}};

    logic            lfsr_mode_q;
    logic [NUM_IN:0] remain_q;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        start_vec = '0;
        zero_run  = 1'b0;
        if (bus.mode) begin
            // An all-zero seed would lock the LFSR, so it is replaced by 1.
            start_vec = (bus.seed == '0) ? NUM_IN'(1) : bus.seed;
            zero_run  = (bus.num_vectors == '0);
        end
        last_vec = lfsr_mode_q ? (remain_q == (NUM_IN+1)'(1)) : (pi_q == '1);
        next_vec = lfsr_mode_q ? ({1'b0, pi_q[NUM_IN-1:1]} ^ (pi_q[0] ? TAPS : '0))
                               : pi_q + NUM_IN'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_mode_q <= 1'b0;
            remain_q    <= '0;
        end else if (accept) begin
            lfsr_mode_q <= bus.mode;
            remain_q    <= (bus.num_vectors > MAX_VECTORS) ? MAX_VECTORS : bus.num_vectors;
        end else if (sample) begin
            remain_q    <= remain_q - (NUM_IN+1)'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.mode, bus.seed, bus.num_vectors};
    assign start_vec  = '0;
    assign zero_run   = 1'b0;
    assign last_vec   = (pi_q == '1);
    assign next_vec   = pi_q + NUM_IN'(1);
`endif

    always_comb begin
        state_d = state_q;
        accept  = bus.start && (state_q != RUN);
        sample  = (state_q == RUN) && (settle_q == SETTLE_LAST);
        unique case (state_q)
            IDLE, DONE: if (accept) state_d = zero_run ? DONE : RUN;
            RUN:        if (sample && last_vec) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        diff_bits = bus.po_exact ^ bus.po_approx;
        mismatch  = |diff_bits;
        abs_diff  = (bus.po_exact >= bus.po_approx) ? (bus.po_exact - bus.po_approx)
                                                    : (bus.po_approx - bus.po_exact);
    end

    // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_q          <= '0;
            pi_q              <= '0;
            err_count_q       <= '0;
            hd_sum_q          <= '0;
            max_abs_err_q     <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else if (accept) begin
            settle_q          <= '0;
            pi_q              <= start_vec;
            err_count_q       <= '0;
            hd_sum_q          <= '0;
            max_abs_err_q     <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else if (state_q == RUN) begin
            if (sample) begin
                settle_q <= '0;
                pi_q     <= next_vec;
                if (mismatch) begin
                    err_count_q <= err_count_q + (NUM_IN+1)'(1);
                    hd_sum_q    <= hd_sum_q + (NUM_IN+6)'($countones(diff_bits));
                    if (abs_diff > max_abs_err_q) max_abs_err_q <= abs_diff;
                    if (!first_err_valid_q) begin
                        first_err_vec_q   <= pi_q;
                        first_err_valid_q <= 1'b1;
                    end
                end
            end else begin
                settle_q <= settle_q + CW'(1);
            end
        end
    end

    assign bus.pi              = pi_q;
    assign bus.busy            = (state_q == RUN);
    assign bus.done            = (state_q == DONE);
    assign bus.err_count       = err_count_q;
    assign bus.hd_sum          = hd_sum_q;
    assign bus.max_abs_err     = max_abs_err_q;
    assign bus.first_err_vec   = first_err_vec_q;
    assign bus.first_err_valid = first_err_valid_q;
endmodule

// File: tb/tb_partition_error_sweeper.sv
// Self-checking bench for partition_error_sweeper: random partition tables, metrics from a plain model.
// Exercises SETTLE=1 and SETTLE=3 instances; the LFSR scenario follows SWEEP_LFSR_EN.
`timescale 1ns/1ps
module tb_partition_error_sweeper;
    localparam int NI = 7;
    localparam int NO = 4;
    localparam int NV = 1 << NI;

    typedef struct {
        int err;
        int hd;
        int mx;
        int first;
        bit fv;
    } metrics_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    partition_error_sweeper_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus1();
    partition_error_sweeper_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus3();

    partition_error_sweeper #(.NUM_IN(NI), .NUM_OUT(NO), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    partition_error_sweeper #(.NUM_IN(NI), .NUM_OUT(NO), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    logic [NO-1:0] exact_tab  [NV];
    logic [NO-1:0] approx_tab [NV];

    assign bus1.po_exact  = exact_tab[bus1.pi];
    assign bus1.po_approx = approx_tab[bus1.pi];
    assign bus3.po_exact  = exact_tab[bus3.pi];
    assign bus3.po_approx = approx_tab[bus3.pi];

    int errors = 0;
    int checks = 0;
    int vec_q[$];
    int obs_q[$];

    function automatic logic [32:0] got1();
        return {bus1.err_count, bus1.hd_sum, bus1.max_abs_err, bus1.first_err_vec, bus1.first_err_valid};
    endfunction

    function automatic logic [32:0] got3();
        return {bus3.err_count, bus3.hd_sum, bus3.max_abs_err, bus3.first_err_vec, bus3.first_err_valid};
    endfunction

    function automatic logic [32:0] pack(input metrics_t m);
        return {8'(m.err), 13'(m.hd), 4'(m.mx), 7'(m.first), m.fv};
    endfunction

    // Reference: walk the applied vectors in order and accumulate the metrics arithmetically.
    function automatic metrics_t model();
        metrics_t m;
        m = '{err: 0, hd: 0, mx: 0, first: 0, fv: 1'b0};
        foreach (vec_q[i]) begin
            int v, e, a, d;
            v = vec_q[i];
            e = int'(exact_tab[v]);
            a = int'(approx_tab[v]);
            if (e != a) begin
                m.err++;
                m.hd += $countones(e ^ a);
                d = (e > a) ? e - a : a - e;
                if (d > m.mx) m.mx = d;
                if (!m.fv) begin
                    m.fv    = 1'b1;
                    m.first = v;
                end
            end
        end
        return m;
    endfunction

    task automatic set_exhaustive();
        vec_q.delete();
        for (int i = 0; i < NV; i++) vec_q.push_back(i);
    endtask

    task automatic fill_tables(input int pct);
        for (int i = 0; i < NV; i++) begin
            exact_tab[i]  = NO'($urandom);
            approx_tab[i] = ($urandom_range(99) < pct) ? exact_tab[i] ^ NO'($urandom_range(15, 1))
                                                       : exact_tab[i];
        end
    endtask

    // Starts a run on the SETTLE=1 instance and records pi each cycle until done (bounded).
    task automatic run1(output int cycles);
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        cycles = 0;
        obs_q.delete();
        while (!bus1.done && cycles < 1000) begin
            obs_q.push_back(int'(bus1.pi));
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    function automatic int count_bad_exhaustive();
        int bad;
        bad = (obs_q.size() == NV) ? 0 : 1;
        foreach (obs_q[i]) if (obs_q[i] != i) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (got1() !== 33'd0) begin errors++; $display("FAIL reset_metrics got %h want 0", got1()); end
        checks++; if ({bus1.pi, bus1.busy, bus1.done} !== '0) begin errors++;
            $display("FAIL reset_ctrl got pi=%0d busy=%0b done=%0b want 0", bus1.pi, bus1.busy, bus1.done); end
        rst_n = 1'b1;
        bus1.start = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%0b want 0", bus1.busy); end
    endtask

    task automatic test_clean();
        int cycles;
        metrics_t m;
        fill_tables(0);
        set_exhaustive();
        m = model();
        run1(cycles);
        checks++; if (cycles != NV) begin errors++; $display("FAIL clean_latency got %0d want %0d", cycles, NV); end
        checks++; if (count_bad_exhaustive() != 0) begin errors++;
            $display("FAIL clean_order got %0d bad vectors want 0", count_bad_exhaustive()); end
        checks++; if (got1() !== pack(m) || m.err != 0) begin errors++;
            $display("FAIL clean_metrics got %h want %h", got1(), pack(m)); end
        checks++; if ({bus1.busy, bus1.done} !== 2'b01) begin errors++;
            $display("FAIL clean_flags got busy=%0b done=%0b want 0 1", bus1.busy, bus1.done); end
    endtask

    task automatic test_lsb_flip();
        int bad;
        for (int i = 0; i < NV; i++) begin
            exact_tab[i]  = NO'($urandom);
            approx_tab[i] = exact_tab[i] ^ 4'b0001;
        end
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        bad = 0;
        for (int k = 1; k <= NV; k++) begin
            @(posedge clk); #1;
            if (int'(bus1.err_count) != k) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL lsb_running_count got %0d bad cycles want 0", bad); end
        checks++; if (bus1.done !== 1'b1) begin errors++; $display("FAIL lsb_done got %0b want 1", bus1.done); end
        checks++; if (got1() !== {8'd128, 13'd128, 4'd1, 7'd0, 1'b1}) begin errors++;
            $display("FAIL lsb_metrics got %h want err=128 hd=128 max=1 first=0 valid=1", got1()); end
    endtask

    task automatic test_single_diff();
        int cycles;
        metrics_t m;
        fill_tables(0);
        approx_tab[7'h55] = exact_tab[7'h55] ^ 4'b1111;
        set_exhaustive();
        m = model();
        run1(cycles);
        checks++; if (cycles != NV) begin errors++; $display("FAIL single_latency got %0d want %0d", cycles, NV); end
        checks++; if (got1() !== pack(m) || m.err != 1 || m.hd != 4 || m.first != 'h55) begin errors++;
            $display("FAIL single_metrics got %h want %h", got1(), pack(m)); end
    endtask

    task automatic test_random();
        int cycles;
        metrics_t m;
        for (int r = 0; r < 3; r++) begin
            fill_tables(10 + 30 * r);
            set_exhaustive();
            m = model();
            run1(cycles);
            checks++; if (cycles != NV || got1() !== pack(m)) begin errors++;
                $display("FAIL random_%0d got cycles=%0d metrics=%h want %0d %h", r, cycles, got1(), NV, pack(m)); end
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        metrics_t m;
        fill_tables(50);
        set_exhaustive();
        run1(cycles);
        fill_tables(0);
        for (int i = 100; i < NV; i++) approx_tab[i] = exact_tab[i] ^ 4'b0110;
        m = model();
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        checks++; if ({bus1.busy, bus1.done, got1()} !== {2'b10, 33'd0}) begin errors++;
            $display("FAIL b2b_restart got busy=%0b done=%0b metrics=%h want 1 0 0", bus1.busy, bus1.done, got1()); end
        cycles = 0;
        while (!bus1.done && cycles < 1000) begin @(posedge clk); #1; cycles++; end
        checks++; if (cycles != NV || got1() !== pack(m)) begin errors++;
            $display("FAIL b2b_metrics got cycles=%0d metrics=%h want %0d %h", cycles, got1(), NV, pack(m)); end
    endtask

    task automatic test_settle();
        metrics_t m;
        fill_tables(40);
        set_exhaustive();
        m = model();
        bus3.start = 1'b1;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        for (int j = 0; j < 3 * NV; j++) begin
            checks++; if (int'(bus3.pi) != (j / 3) % NV || bus3.busy !== 1'b1) begin errors++;
                $display("FAIL settle_hold j=%0d got pi=%0d busy=%0b want %0d 1", j, bus3.pi, bus3.busy, (j / 3) % NV); end
            if (j == 9)  bus3.start = 1'b1;
            if (j == 10) bus3.start = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if ({bus3.busy, bus3.done} !== 2'b01) begin errors++;
            $display("FAIL settle_done got busy=%0b done=%0b want 0 1", bus3.busy, bus3.done); end
        checks++; if (got3() !== pack(m)) begin errors++; $display("FAIL settle_metrics got %h want %h", got3(), pack(m)); end
    endtask

    task automatic test_reset_midrun();
        int cycles;
        metrics_t m;
        fill_tables(80);
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (49) begin @(posedge clk); #1; end
        checks++; if (bus1.err_count === '0) begin errors++; $display("FAIL midrun_progress got err_count=0 want nonzero"); end
        rst_n = 1'b0;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        checks++; if ({bus1.pi, bus1.busy, bus1.done, got1()} !== '0) begin errors++;
            $display("FAIL midrun_reset got pi=%0d busy=%0b done=%0b metrics=%h want 0",
                     bus1.pi, bus1.busy, bus1.done, got1()); end
        bus1.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_tables(0);
        set_exhaustive();
        m = model();
        run1(cycles);
        checks++; if (cycles != NV || got1() !== pack(m) || count_bad_exhaustive() != 0) begin errors++;
            $display("FAIL midrun_rerun got cycles=%0d metrics=%h want %0d %h", cycles, got1(), NV, pack(m)); end
    endtask

`ifdef SWEEP_LFSR_EN
    task automatic test_lfsr();
        int cycles;
        int dup;
        bit seen [NV];
        metrics_t m;
        bus1.mode = 1'b1;
        fill_tables(50);
        // Seed 0 must start at 1; then exactly 10 distinct nonzero vectors.
        bus1.seed = '0;
        bus1.num_vectors = 8'd10;
        run1(cycles);
        vec_q = obs_q;
        m = model();
        dup = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (obs_q[i]) begin
            if (obs_q[i] == 0 || seen[obs_q[i]]) dup++;
            seen[obs_q[i]] = 1'b1;
        end
        checks++; if (cycles != 10) begin errors++; $display("FAIL lfsr_latency got %0d want 10", cycles); end
        checks++; if (obs_q.size() == 0 || obs_q[0] != 1) begin errors++;
            $display("FAIL lfsr_first_pi got %0d want 1", (obs_q.size() != 0) ? obs_q[0] : -1); end
        checks++; if (dup != 0) begin errors++; $display("FAIL lfsr_distinct got %0d repeats want 0", dup); end
        checks++; if (got1() !== pack(m)) begin errors++; $display("FAIL lfsr_metrics got %h want %h", got1(), pack(m)); end
        // Over-range count clamps to 2^NI-1, which a maximal LFSR covers without repeats.
        bus1.seed = 7'h2A;
        bus1.num_vectors = 8'd200;
        run1(cycles);
        dup = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (obs_q[i]) begin
            if (obs_q[i] == 0 || seen[obs_q[i]]) dup++;
            seen[obs_q[i]] = 1'b1;
        end
        checks++; if (cycles != NV - 1 || dup != 0 || obs_q[0] != 'h2A) begin errors++;
            $display("FAIL lfsr_clamp got cycles=%0d repeats=%0d want %0d 0", cycles, dup, NV - 1); end
        bus1.num_vectors = '0;
        run1(cycles);
        checks++; if (cycles != 0 || bus1.done !== 1'b1 || got1() !== 33'd0) begin errors++;
            $display("FAIL lfsr_zero got cycles=%0d done=%0b metrics=%h want 0 1 0", cycles, bus1.done, got1()); end
        bus1.mode = 1'b0;
    endtask
`else
    task automatic test_mode_ignored();
        int cycles;
        metrics_t m;
        fill_tables(30);
        set_exhaustive();
        m = model();
        bus1.mode = 1'b1;
        bus1.seed = 7'h13;
        bus1.num_vectors = 8'd3;
        run1(cycles);
        checks++; if (cycles != NV || count_bad_exhaustive() != 0 || got1() !== pack(m)) begin errors++;
            $display("FAIL mode_ignored got cycles=%0d metrics=%h want %0d %h", cycles, got1(), NV, pack(m)); end
        bus1.mode = 1'b0;
    endtask
`endif

    initial begin
        bus1.start = 1'b0; bus1.mode = 1'b0; bus1.seed = '0; bus1.num_vectors = '0;
        bus3.start = 1'b0; bus3.mode = 1'b0; bus3.seed = '0; bus3.num_vectors = '0;
        for (int i = 0; i < NV; i++) begin exact_tab[i] = '0; approx_tab[i] = '0; end
        test_reset();
        test_clean();
        test_lsb_flip();
        test_single_diff();
        test_random();
        test_back_to_back();
        test_settle();
        test_reset_midrun();
`ifdef SWEEP_LFSR_EN
        test_lfsr();
`else
        test_mode_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
